// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if: bundles the fetch, data and memory buses of the
// shared I/D memory arbiter.
//   halt                            : stall new grants
//   if_req/if_addr/if_gnt           : fetch request and grant
//   if_rdata/if_valid               : fetched word and its pulse
//   dm_req/dm_we/dm_addr/dm_wdata   : data request (load/store)
//   dm_gnt/dm_rdata/dm_valid        : data grant, load data, done pulse
//   mem_en/mem_we/mem_addr/mem_wdata: memory strobe and write port
//   mem_rdata                       : memory read data
//   busy                            : arbiter not idle
// slave = arbiter side, master = pipeline/memory side.
interface mips_mem_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              halt;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  halt, if_req, if_addr,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_gnt, if_rdata, if_valid,
      output dm_gnt, dm_rdata, dm_valid,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy
   );

   modport master (
      output halt, if_req, if_addr,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_gnt, if_rdata, if_valid,
      input  dm_gnt, dm_rdata, dm_valid,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy
   );
endinterface

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one fixed-latency synchronous memory between
// the fetch stage and the MEM stage, data first with a starvation guard.
//   clock_1 : clock, all state on posedge
//   reset   : synchronous, active-high
//   bus     : mips_mem_arbiter_if.slave (requesters + memory)
module mips_mem_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                clock_1,
   input  logic                reset,
   mips_mem_arbiter_if.slave   bus
);
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_owner_dm;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [2:0]        r_wait_cnt;
   logic [SW-1:0]     r_starve_cnt;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_dm_rdata;

   logic w_if_gnt;
   logic w_dm_gnt;
   logic w_starved;
   logic w_mem_en;
   logic w_done;
   logic w_capture;

   assign w_starved = (r_starve_cnt == SW'(STARVE_MAX));

   always_comb begin
      w_next   = r_state;
      w_if_gnt = 1'b0;
      w_dm_gnt = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!reset && !bus.halt) begin
               // data wins unless fetch has waited out the guard
               if (bus.dm_req && !(bus.if_req && w_starved))
                  w_dm_gnt = 1'b1;
               else if (bus.if_req)
                  w_if_gnt = 1'b1;
            end
            if (w_if_gnt || w_dm_gnt)
               w_next = S_ISSUE;
         end
         S_ISSUE: w_next = r_we ? S_DONE : S_WAIT;
         S_WAIT: begin
            if (r_wait_cnt == 3'd1)
               w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // last WAIT cycle is exactly MEM_LAT after mem_en
   assign w_capture = (r_state == S_WAIT) &&
                      (r_wait_cnt == 3'd1);

   always_ff @(posedge clock_1) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_owner_dm   <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wait_cnt   <= '0;
         r_starve_cnt <= '0;
         r_if_rdata   <= '0;
         r_dm_rdata   <= '0;
      end else begin
         r_state <= w_next;
         if (w_if_gnt || w_dm_gnt) begin
            r_owner_dm <= w_dm_gnt;
            r_we       <= w_dm_gnt & bus.dm_we;
            r_addr     <= w_dm_gnt ? bus.dm_addr
                                   : bus.if_addr;
            r_wdata    <= w_dm_gnt ? bus.dm_wdata
                                   : '0;
         end
         if (!bus.if_req || w_if_gnt)
            r_starve_cnt <= '0;
         else if (w_dm_gnt && !w_starved)
            r_starve_cnt <= r_starve_cnt + 1'b1;
         if (r_state == S_ISSUE)
            r_wait_cnt <= 3'(MEM_LAT);
         else if (r_state == S_WAIT)
            r_wait_cnt <= r_wait_cnt - 3'd1;
         if (w_capture) begin
            if (r_owner_dm)
               r_dm_rdata <= bus.mem_rdata;
            else
               r_if_rdata <= bus.mem_rdata;
         end
      end
   end

   // reset suppresses strobes and pulses in the cycle it is applied
   assign w_mem_en = (r_state == S_ISSUE) && !reset;
   assign w_done   = (r_state == S_DONE) && !reset;

   assign bus.if_gnt    = w_if_gnt;
   assign bus.dm_gnt    = w_dm_gnt;
   assign bus.mem_en    = w_mem_en;
   assign bus.mem_we    = w_mem_en & r_we;
   assign bus.mem_addr  = w_mem_en ? r_addr : '0;
   assign bus.mem_wdata = w_mem_en ? r_wdata : '0;
   assign bus.if_valid  = w_done & ~r_owner_dm;
   assign bus.dm_valid  = w_done & r_owner_dm;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.dm_rdata  = r_dm_rdata;
   assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed plus random checks of the arbiter
// against a transaction-level timing model; extra MEM_LAT=1/7 builds.
module tb_mips_mem_arbiter;
   localparam int AW   = 10;
   localparam int DW   = 32;
   localparam int LAT  = 2;
   localparam int SMAX = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mips_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b2 ();
   mips_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
   mips_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b7 ();

   mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT),
      .STARVE_MAX(SMAX)) dut2 (.clock_1(clk), .reset(rst), .bus(b2.slave));
   mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1),
      .STARVE_MAX(SMAX)) dut1 (.clock_1(clk), .reset(rst), .bus(b1.slave));
   mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(7),
      .STARVE_MAX(SMAX)) dut7 (.clock_1(clk), .reset(rst), .bus(b7.slave));

   function automatic logic [31:0] f(int i);
      if (i == 5) return 32'h2800_0001;
      return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   // memory: initial load on first edge, then read pipelines
   logic [31:0] mem [1024];
   logic [31:0] p2 [LAT];
   logic [31:0] p1;
   logic [31:0] p7 [7];
   logic booted = 1'b0;

   always @(posedge clk) begin
      if (!booted) begin
         for (int i = 0; i < 1024; i++) mem[i] <= f(i);
         booted <= 1'b1;
      end else if (b2.mem_en && b2.mem_we) begin
         mem[b2.mem_addr] <= b2.mem_wdata;
      end
      p2[0] <= (b2.mem_en && !b2.mem_we) ? mem[b2.mem_addr] : 32'hBAD0_BAD0;
      for (int k = 1; k < LAT; k++) p2[k] <= p2[k-1];
      p1 <= b1.mem_en ? mem[b1.mem_addr] : 32'hBAD1_BAD1;
      p7[0] <= b7.mem_en ? mem[b7.mem_addr] : 32'hBAD7_BAD7;
      for (int k = 1; k < 7; k++) p7[k] <= p7[k-1];
   end
   assign b2.mem_rdata = p2[LAT-1];
   assign b1.mem_rdata = p1;
   assign b7.mem_rdata = p7[6];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // transaction-level reference for dut2
   logic [31:0] ref_mem [1024];
   int cyc = 0, next_free = 0, starve = 0;
   bit infl = 0, t_dm, t_we;
   int t_g;
   logic [AW-1:0] t_a;
   logic [DW-1:0] t_d, t_rd, e_ifr = '0, e_dmr = '0;
   bit gq [$];
   bit g_if, g_dm;
   int ifv_cyc, dmv_cyc, g1_cyc, v1_cyc, g7_cyc, v7_cyc;

   task automatic tick();
      bit eg_if, eg_dm, e_en, e_iv, e_dv, e_busy;
      int done;
      @(negedge clk);
      g_if = b2.if_gnt;
      g_dm = b2.dm_gnt;
      if (b2.if_valid) ifv_cyc = cyc;
      if (b2.dm_valid) dmv_cyc = cyc;
      if (b1.if_gnt) g1_cyc = cyc;
      if (b1.if_valid) v1_cyc = cyc;
      if (b7.if_gnt) g7_cyc = cyc;
      if (b7.if_valid) v7_cyc = cyc;
      if (rst) begin
         infl = 0; starve = 0; e_ifr = '0; e_dmr = '0;
         next_free = cyc + 1;
      end else begin
         eg_if = 0; eg_dm = 0;
         if (cyc >= next_free && !b2.halt) begin
            if (b2.dm_req && !(b2.if_req && starve == SMAX)) eg_dm = 1;
            else if (b2.if_req) eg_if = 1;
         end
         done = infl ? (t_g + (t_we ? 2 : 2 + LAT)) : -1;
         e_en = infl && cyc == t_g + 1;
         e_iv = infl && cyc == done && !t_dm;
         e_dv = infl && cyc == done && t_dm;
         e_busy = infl && cyc > t_g && cyc <= done;
         if (infl && cyc == done && !t_we) begin
            if (t_dm) e_dmr = t_rd; else e_ifr = t_rd;
         end
         chk("if_gnt", b2.if_gnt, eg_if);
         chk("dm_gnt", b2.dm_gnt, eg_dm);
         chk("mem_en", b2.mem_en, e_en);
         chk("mem_we", b2.mem_we, e_en && t_we);
         chk("mem_addr", b2.mem_addr, e_en ? t_a : '0);
         if (e_en && t_we) chk("mem_wdata", b2.mem_wdata, t_d);
         if (!e_en) chk("mem_wdata_idle", b2.mem_wdata, 0);
         chk("if_valid", b2.if_valid, e_iv);
         chk("dm_valid", b2.dm_valid, e_dv);
         chk("if_rdata", b2.if_rdata, e_ifr);
         chk("dm_rdata", b2.dm_rdata, e_dmr);
         chk("busy", b2.busy, e_busy);
         if (infl && cyc == done) infl = 0;
         if (!b2.if_req || eg_if) starve = 0;
         else if (eg_dm && starve < SMAX) starve++;
         if (eg_if || eg_dm) begin
            infl = 1; t_g = cyc; t_dm = eg_dm;
            t_we = eg_dm && b2.dm_we;
            t_a = eg_dm ? b2.dm_addr : b2.if_addr;
            t_d = b2.dm_wdata;
            t_rd = ref_mem[t_a];
            if (t_we) ref_mem[t_a] = t_d;
            next_free = cyc + (t_we ? 3 : 3 + LAT);
            gq.push_back(eg_dm);
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   int t0;
   logic [4:0] order;

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = f(i);
      rst = 1'b1;
      b2.halt = 0; b2.if_req = 0; b2.if_addr = '0;
      b2.dm_req = 0; b2.dm_we = 0; b2.dm_addr = '0; b2.dm_wdata = '0;
      b1.halt = 0; b1.if_req = 0; b1.if_addr = '0;
      b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = '0; b1.dm_wdata = '0;
      b7.halt = 0; b7.if_req = 0; b7.if_addr = '0;
      b7.dm_req = 0; b7.dm_we = 0; b7.dm_addr = '0; b7.dm_wdata = '0;
      ifv_cyc = -100; dmv_cyc = -100;
      g1_cyc = -100; v1_cyc = -100; g7_cyc = -100; v7_cyc = -100;
      @(posedge clk); #1;
      tick(); tick();
      rst = 1'b0;
      tick(); tick();

      // single fetch of word 5
      b2.if_req = 1; b2.if_addr = 10'd5; t0 = cyc;
      tick();
      b2.if_req = 0;
      repeat (6) tick();
      chk("fetch_latency", ifv_cyc - t0, 4);
      chk("fetch_data", b2.if_rdata, 32'h2800_0001);

      // store then load of word 9
      b2.dm_req = 1; b2.dm_we = 1; b2.dm_addr = 10'd9;
      b2.dm_wdata = 32'hDEAD_BEEF; t0 = cyc;
      tick();
      b2.dm_req = 0;
      repeat (3) tick();
      chk("store_latency", dmv_cyc - t0, 2);
      chk("store_keeps_rdata", b2.dm_rdata, 32'h0);
      b2.dm_req = 1; b2.dm_we = 0; b2.dm_wdata = 32'h1111_2222; t0 = cyc;
      tick();
      b2.dm_req = 0;
      repeat (6) tick();
      chk("load_latency", dmv_cyc - t0, 4);
      chk("load_data", b2.dm_rdata, 32'hDEAD_BEEF);

      // both held: dm x4 then if
      gq.delete();
      b2.if_req = 1; b2.if_addr = 10'd3;
      b2.dm_req = 1; b2.dm_we = 0; b2.dm_addr = 10'd7;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (g_if) break;
      end
      b2.if_req = 0; b2.dm_req = 0;
      order = '0;
      for (int k = 0; k < 5 && k < gq.size(); k++) order[4-k] = gq[k];
      chk("starve_count", gq.size(), 5);
      chk("starve_order", order, 5'b11110);
      repeat (8) tick();

      // halt after a fetch grant
      b2.if_req = 1; b2.if_addr = 10'd20;
      tick();
      chk("halt_pre_gnt", g_if, 1);
      b2.if_req = 0; b2.halt = 1;
      b2.dm_req = 1; b2.dm_we = 0; b2.dm_addr = 10'd1023;
      gq.delete(); ifv_cyc = -100;
      repeat (10) tick();
      chk("halt_completes", ifv_cyc >= 0, 1);
      chk("halt_no_gnt", gq.size(), 0);
      b2.halt = 0;
      tick();
      chk("unhalt_gnt", g_dm, 1);
      b2.dm_req = 0;
      repeat (6) tick();

      // reset during WAIT of a load
      b2.dm_req = 1; b2.dm_we = 0; b2.dm_addr = 10'd9;
      tick();
      b2.dm_req = 0;
      tick(); tick();
      rst = 1; dmv_cyc = -100; ifv_cyc = -100;
      tick();
      rst = 0;
      repeat (6) tick();
      chk("rst_no_dmv", dmv_cyc, -100);
      chk("rst_no_ifv", ifv_cyc, -100);
      b2.if_req = 1; b2.if_addr = 10'd5;
      tick();
      b2.if_req = 0;
      repeat (6) tick();
      chk("post_rst_fetch", b2.if_rdata, 32'h2800_0001);

      // random traffic
      for (int n = 0; n < 2000; n++) begin
         if (!b2.if_req || g_if) begin
            b2.if_req = ($urandom_range(2) == 0);
            b2.if_addr = ($urandom_range(3) == 0) ? 10'd1023 : 10'($urandom);
         end else if ($urandom_range(31) == 0) begin
            b2.if_req = 0;
         end
         if (!b2.dm_req || g_dm) begin
            b2.dm_req = ($urandom_range(1) == 0);
            b2.dm_we = $urandom_range(1) == 1;
            b2.dm_addr = 10'($urandom_range(15));
            b2.dm_wdata = $urandom;
         end
         b2.halt = ($urandom_range(9) == 0);
         tick();
      end
      b2.if_req = 0; b2.dm_req = 0; b2.halt = 0;
      repeat (12) tick();

      // MEM_LAT = 1 and 7 builds
      b1.if_req = 1; b1.if_addr = 10'd5;
      b7.if_req = 1; b7.if_addr = 10'd1023;
      tick();
      b1.if_req = 0; b7.if_req = 0;
      repeat (12) tick();
      chk("lat1_latency", v1_cyc - g1_cyc, 3);
      chk("lat7_latency", v7_cyc - g7_cyc, 9);
      chk("lat1_data", b1.if_rdata, ref_mem[5]);
      chk("lat7_data", b7.if_rdata, ref_mem[1023]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
